// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - program counter and fetch sequencer feeding the program-memory address decoder
//
// Optional build macro: PC_BOUNDS_CHECK_EN (range-checks every new PC against
// [PROG_BASE, PROG_LAST] and enters FAULT on a violation).
//
// Ports:
//   clk            in   1   system clock, all state updates on posedge
//   rst            in   1   synchronous reset, active high
//   stall          in   1   hold PC this cycle
//   branch_taken   in   1   load branch_target
//   branch_target  in  32   branch destination
//   jump           in   1   load jump_target (beats branch)
//   jump_target    in  32   jump destination
//   halt_req       in   1   enter HALT (beats everything but rst)
//   pc_out         out 32   current fetch address, to decoder address_in
//   fetch_valid    out  1   pc_out is a live fetch
//   pc_q1          out 32   pc_out delayed one cycle, aligned with decoder outputs
//   valid_q1       out  1   fetch_valid delayed one cycle
//   pc_fault       out  1   sticky out-of-range fault (bounds-check build only)
//   state          out  2   00 RESET, 01 RUN, 10 HALT, 11 FAULT

module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h31B0,
  parameter logic [31:0] PROG_BASE    = 32'h31B0,
  parameter logic [31:0] PROG_LAST    = 32'h35AF,
  parameter logic [31:0] PC_STEP      = 32'd1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        halt_req,
  output logic [31:0] pc_out,
  output logic        fetch_valid,
  output logic [31:0] pc_q1,
  output logic        valid_q1,
  output logic        pc_fault,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_RESET = 2'b00,
    ST_RUN   = 2'b01,
    ST_HALT  = 2'b10,
    ST_FAULT = 2'b11
  } state_t;

  state_t      cur_state;
  state_t      nxt_state;
  logic [31:0] pc;
  logic [31:0] pc_nxt;
  logic [31:0] cand;
  logic        load;

`ifdef PC_BOUNDS_CHECK_EN
  logic fault;
  logic fault_nxt;
  logic cand_ok;

  assign cand_ok  = (cand >= PROG_BASE) && (cand <= PROG_LAST);
  assign pc_fault = fault;
`else
  logic unused_bounds;

  assign unused_bounds = ^{PROG_BASE, PROG_LAST};
  assign pc_fault      = 1'b0;
`endif

  assign pc_out      = pc;
  assign fetch_valid = (cur_state == ST_RUN);
  assign state       = cur_state;

  // Candidate PC selection: halt > jump > branch > stall > increment.
  // A redirect wins over stall, so stall only matters with no redirect.
  always_comb begin
    nxt_state = cur_state;
    pc_nxt    = pc;
    cand      = pc + PC_STEP;
    load      = 1'b0;
`ifdef PC_BOUNDS_CHECK_EN
    fault_nxt = fault;
`endif
    case (cur_state)
      // RESET_VECTOR is fetched once before any increment.
      ST_RESET: nxt_state = ST_RUN;
      ST_RUN: begin
        if (halt_req) begin
          nxt_state = ST_HALT;
        end else begin
          if (jump) begin
            cand = jump_target;
            load = 1'b1;
          end else if (branch_taken) begin
            cand = branch_target;
            load = 1'b1;
          end else if (!stall) begin
            load = 1'b1;
          end
          if (load) begin
`ifdef PC_BOUNDS_CHECK_EN
            // An illegal PC is never loaded; PC stays at the last legal value.
            if (cand_ok) begin
              pc_nxt = cand;
            end else begin
              nxt_state = ST_FAULT;
              fault_nxt = 1'b1;
            end
`else
            pc_nxt = cand;
`endif
          end
        end
      end
      ST_HALT:  nxt_state = ST_HALT;
      ST_FAULT: nxt_state = ST_FAULT;
      default:  nxt_state = ST_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_state <= ST_RESET;
      pc        <= RESET_VECTOR;
      pc_q1     <= 32'h0;
      valid_q1  <= 1'b0;
`ifdef PC_BOUNDS_CHECK_EN
      fault     <= 1'b0;
`endif
    end else begin
      cur_state <= nxt_state;
      pc        <= pc_nxt;
      // Delay stage is never stalled so it always tracks the registered decoder.
      pc_q1     <= pc;
      valid_q1  <= fetch_valid;
`ifdef PC_BOUNDS_CHECK_EN
      fault     <= fault_nxt;
`endif
    end
  end

endmodule

// File: doc/pc_fetch_unit.md
Name: pc_fetch_unit

Overview:
Program counter and fetch sequencer that drives the 32-bit address into the program-memory address decoder (address_in). Generates sequential, branch and jump fetch addresses with stall and halt control. Provides a one-cycle-delayed PC/valid pair aligned with the decoder's registered cs_p/address_out, so the decode stage can pair each instruction word with its PC. Program memory is word-addressed: one address step equals one instruction.

Parameters:
RESET_VECTOR, 32'h31B0, PC value loaded on reset (first fetch address)
PROG_BASE, 32'h31B0, lowest legal program address (used only with bounds check)
PROG_LAST, 32'h35AF, highest legal program address (used only with bounds check)
PC_STEP, 32'd1, sequential increment

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  synchronous reset, active high
stall  in  1  hold PC this cycle
branch_taken  in  1  load branch_target
branch_target  in  32  branch destination
jump  in  1  load jump_target
jump_target  in  32  jump destination
halt_req  in  1  enter HALT
pc_out  out  32  current fetch address, to decoder address_in
fetch_valid  out  1  pc_out is a live fetch
pc_q1  out  32  pc_out delayed one cycle, aligned with decoder outputs
valid_q1  out  1  fetch_valid delayed one cycle
pc_fault  out  1  sticky out-of-range fault (bounds-check build only)
state  out  2  00 RESET, 01 RUN, 10 HALT, 11 FAULT

Behaviour:
- Synchronous active-high reset, sampled at posedge clk. While rst=1: pc_out=RESET_VECTOR, fetch_valid=0, pc_q1=0, valid_q1=0, pc_fault=0, state=RESET. rst overrides every other input in any state, including mid-HALT and mid-FAULT.
- RESET: first cycle after rst deasserts -> RUN. pc_out stays RESET_VECTOR and fetch_valid goes 1, so RESET_VECTOR is fetched once before any increment.
- RUN: fetch_valid=1. Next PC is chosen by priority, highest first:
  - halt_req: go to HALT, PC held.
  - jump: PC = jump_target.
  - branch_taken: PC = branch_target.
  - stall: PC held.
  - otherwise: PC = pc_out + PC_STEP.
- Priority consequences: jump beats branch when both are asserted. A redirect (jump or branch) beats stall.
- Arithmetic: 32-bit modulo. 32'hFFFFFFFF + 1 = 32'h0, with no flag (without bounds check).
- Target alignment: targets are loaded verbatim; no alignment masking.
- HALT: fetch_valid=0, PC frozen, all control inputs ignored. Exit only via rst.
- FAULT (bounds-check build only): fetch_valid=0, PC frozen at the last legal value, pc_fault=1. Exit only via rst.
- Delay stage: pc_q1 <= pc_out and valid_q1 <= fetch_valid every cycle, never stalled. This gives one-cycle latency to match the registered decoder.
- Latency:
  - Redirect asserted in cycle n appears on pc_out in cycle n+1 and on pc_q1 in cycle n+2.
  - Inputs are ignored in RESET state.

Optional Feature:
PC_BOUNDS_CHECK_EN
- Defined:
  - Every candidate next PC (increment, branch or jump) is compared against [PROG_BASE, PROG_LAST], inclusive.
  - If out of range, the PC is not loaded; the next state is FAULT and pc_fault goes 1 in that same update.
  - halt_req still takes priority over a fault.
  - Stall involves no new PC, so no check is made.
- Undefined:
  - No comparators; pc_fault is tied 0 and FAULT is unreachable.
  - Out-of-range PCs propagate to the decoder, which deasserts chip select (cs_p=1).

Test Plan:
1. rst=1 for 2 cycles, then 0, no other inputs -> during reset pc_out=0x31B0, fetch_valid=0, state=00. Cycle 1: state=01, pc=0x31B0, valid=1. Cycle 2: pc=0x31B1. Cycle 3: pc=0x31B2. pc_q1 lags by 1 cycle.
2. At pc=0x31B4, stall=1 for 3 cycles -> pc_out holds 0x31B4 for 3 cycles, then 0x31B5. pc_q1 shows 0x31B4 one cycle later. valid stays 1.
3. jump=1 (0x3300) and branch_taken=1 (0x3200) together, also with stall=1 -> next pc_out=0x3300. Repeat with branch alone plus stall -> 0x3200.
4. halt_req=1 with jump=1 -> state=10, pc frozen, fetch_valid=0, valid_q1=0 next cycle. Further jump pulses are ignored. rst mid-HALT -> pc=0x31B0, state=00.
5. With PC_BOUNDS_CHECK_EN: jump to 0x35AF, then free-run -> state=11, pc_fault=1, pc_out=0x35AF, fetch_valid=0. Jump to 0x1000 from 0x31C0 -> same fault with pc=0x31C0. Without the macro: pc reaches 0x35B0 and pc_fault=0.
6. Without the macro: jump to 0xFFFFFFFF, then increment -> pc_out=0x00000000, valid=1.
